// File: rtl/launchpad_pkg.sv
// Shared types and helpers for the launchpad LED path.
// The value-to-coordinate stage and the LED scanner both use this package.
package launchpad_pkg;

  localparam int GRID_DIM = 4;

  typedef logic [1:0] coord_t;
  typedef logic [GRID_DIM*GRID_DIM-1:0] mask_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Row-major LED index: row*4 + col.
  function automatic logic [3:0] led_index(input coord_t row, input coord_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/launchpad_scan_timer.sv
// Column scan timebase for the LED matrix.
// A prescaler counts 0..SCAN_DIV-1. Each wrap advances the column.
// Prescaler count 0 is the blanking cycle of a slot.
module launchpad_scan_timer
  import launchpad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic   clk,
  input  logic   reset_n,
  output coord_t scan_col,
  output logic   blank
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] prescale;

  // Prescaler and column counter; the column advances on prescaler wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      scan_col <= '0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      scan_col <= scan_col + 2'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign blank = (prescale == '0);

endmodule

// File: rtl/launchpad_led_scanner.sv
// Launchpad LED scanner.
// Accepted row/col keys are latched into a 16-bit lit-mask. The mask stays lit
// for HOLD_CYCLES after the most recent accept, then clears. The mask is shown
// one column at a time, with one blanking cycle at the start of each column slot.
module launchpad_led_scanner
  import launchpad_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  coord_t     key_row,
  input  coord_t     key_col,
  output logic       key_ready,
  input  logic       clear,
  output logic [3:0] led_col_n,
  output logic [3:0] led_row,
  output logic       busy
);

  localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  mask_t                mask;
  mask_t                mask_next;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_next;
  logic                 ready_q;
  logic                 accept;
  logic                 expire;
  coord_t               scan_col;
  logic                 blank;
  logic [3:0]           led_col_n_next;
  logic [3:0]           led_row_next;

  launchpad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_col (scan_col),
    .blank    (blank)
  );

  // clear blocks acceptance in the same cycle, so a clear never races a key.
  assign key_ready = ready_q & ~clear;
  assign accept    = key_valid & key_ready;
  assign expire    = (state == ST_SHOW) && (timer == '0);

  // Handshake enable: comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state: clear wins, then accept (even on the expiry cycle), then expiry.
  always_comb begin
    state_next = state;
    if (clear)       state_next = ST_IDLE;
    else if (accept) state_next = ST_SHOW;
    else if (expire) state_next = ST_IDLE;
  end

  // State outputs.
  always_comb begin
    busy = (state == ST_SHOW);
  end

  // Mask and hold-timer updates, with the same priority as the state.
  always_comb begin
    mask_next  = mask;
    timer_next = timer;
    if (clear) begin
      mask_next  = '0;
      timer_next = '0;
    end else if (accept) begin
      mask_next[led_index(key_row, key_col)] = 1'b1;
      timer_next = TIMER_LOAD;
    end else if (expire) begin
      mask_next  = '0;
    end else if (state == ST_SHOW) begin
      timer_next = timer - 1'b1;
    end
  end

  // Mask and hold-timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask  <= '0;
      timer <= '0;
    end else begin
      mask  <= mask_next;
      timer <= timer_next;
    end
  end

  // Pin values for the current scan position. The live mask is used, so mask
  // changes show up mid-slot.
  always_comb begin
    led_col_n_next = 4'hF;
    led_row_next   = 4'h0;
    if (!blank) begin
      led_col_n_next = ~(4'b0001 << scan_col);
      for (int r = 0; r < GRID_DIM; r++) begin
        led_row_next[r] = mask[led_index(coord_t'(r), scan_col)];
      end
    end
  end

  // Registered pin drivers, one cycle behind the mask/scan state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_col_n <= 4'hF;
      led_row   <= 4'h0;
    end else begin
      led_col_n <= led_col_n_next;
      led_row   <= led_row_next;
    end
  end

endmodule

// File: tb/tb_launchpad_led_scanner.sv
// Directed bench for launchpad_led_scanner with SCAN_DIV=4, HOLD_CYCLES=20.
module tb_launchpad_led_scanner;

  logic       clk;
  logic       reset_n;
  logic       key_valid;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       key_ready;
  logic       clear;
  logic [3:0] led_col_n;
  logic [3:0] led_row;
  logic       busy;

  int npass;
  int ntotal;

  launchpad_led_scanner #(
    .SCAN_DIV    (4),
    .HOLD_CYCLES (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_ready (key_ready),
    .clear     (clear),
    .led_col_n (led_col_n),
    .led_row   (led_row),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept_key(input logic [1:0] r, input logic [1:0] c);
    key_valid = 1'b1;
    key_row   = r;
    key_col   = c;
    #1;
    check("accept_ready", 32'(key_ready), 32'd1);
    step();
    key_valid = 1'b0;
  endtask

  // Runs the 20 cycles after an accept: busy must hold for 19 edges and fall
  // on the 20th; each lit column must show its expected row pattern.
  task automatic scan_window(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
    int cnt [4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k < 20) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        case (led_col_n)
          4'hF: check({tag, "_blank_row"}, 32'(led_row), 32'd0);
          4'hE: begin check({tag, "_col0"}, 32'(led_row), 32'(e0)); cnt[0]++; end
          4'hD: begin check({tag, "_col1"}, 32'(led_row), 32'(e1)); cnt[1]++; end
          4'hB: begin check({tag, "_col2"}, 32'(led_row), 32'(e2)); cnt[2]++; end
          4'h7: begin check({tag, "_col3"}, 32'(led_row), 32'(e3)); cnt[3]++; end
          default: check({tag, "_col_onehot"}, 32'(led_col_n), 32'hF);
        endcase
      end else begin
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) check({tag, "_slot_seen"}, 32'(cnt[i] >= 3), 32'd1);
  endtask

  logic [3:0] exp_cols [17] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

  initial begin
    npass     = 0;
    ntotal    = 0;
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_row   = 2'd0;
    key_col   = 2'd0;
    clear     = 1'b0;

    // 1. reset values and scan pattern after release
    repeat (3) step();
    check("rst_key_ready", 32'(key_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_col", 32'(led_col_n), 32'hF);
    check("rst_row", 32'(led_row), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_key_ready_pre", 32'(key_ready), 32'd0);
    for (int e = 0; e < 17; e++) begin
      step();
      if (e == 0) check("rel_key_ready", 32'(key_ready), 32'd1);
      check("scan_col", 32'(led_col_n), 32'(exp_cols[e]));
      check("scan_row", 32'(led_row), 32'd0);
    end

    // 2. single accept (2,1)
    accept_key(2'd2, 2'd1);
    check("t2_busy", 32'(busy), 32'd1);
    scan_window("t2", 4'b0000, 4'b0100, 4'b0000, 4'b0000);

    // 3. accept (0,0), then (3,3) ten cycles later
    accept_key(2'd0, 2'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      check("t3_busy_gap", 32'(busy), 32'd1);
    end
    accept_key(2'd3, 2'd3);
    scan_window("t3", 4'b0001, 4'b0000, 4'b0000, 4'b1000);

    // 4. accept (1,2) exactly on the expiry cycle of an earlier (0,0)
    accept_key(2'd0, 2'd0);
    for (int k = 0; k < 19; k++) begin
      step();
      check("t4_busy_hold", 32'(busy), 32'd1);
    end
    accept_key(2'd1, 2'd2);
    check("t4_busy", 32'(busy), 32'd1);
    scan_window("t4", 4'b0001, 4'b0000, 4'b0010, 4'b0000);

    // 5. clear together with key_valid (0,3) over a lit mask
    accept_key(2'd2, 2'd2);
    step();
    step();
    clear     = 1'b1;
    key_valid = 1'b1;
    key_row   = 2'd0;
    key_col   = 2'd3;
    #1;
    check("t5_ready_clear", 32'(key_ready), 32'd0);
    step();
    clear     = 1'b0;
    key_valid = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    #1;
    check("t5_ready_after", 32'(key_ready), 32'd1);
    for (int k = 0; k < 17; k++) begin
      step();
      check("t5_row", 32'(led_row), 32'd0);
      check("t5_busy_stay", 32'(busy), 32'd0);
    end

    // 6. asynchronous reset mid-hold
    accept_key(2'd3, 2'd0);
    repeat (5) step();
    check("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_col", 32'(led_col_n), 32'hF);
    check("t6_row", 32'(led_row), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_key_ready", 32'(key_ready), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("t6_rel_ready", 32'(key_ready), 32'd1);
    check("t6_rel_blank", 32'(led_col_n), 32'hF);
    step();
    check("t6_rel_col0", 32'(led_col_n), 32'hE);
    for (int k = 0; k < 16; k++) begin
      check("t6_mask_row", 32'(led_row), 32'd0);
      check("t6_mask_busy", 32'(busy), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
